// File: rtl/display_arbiter.sv
// display_arbiter: two-requester owner arbitration for the seven-segment value.
// A requester that wins ownership keeps it for at least HOLD_CYCLES cycles;
// after that the other requester can take over. Round-robin bit rr breaks ties in IDLE.
// Optional build macro DISPLAY_ARB_TIMEOUT_EN: release ownership (and blank the
// display) after IDLE_TIMEOUT cycles without a transfer.
module display_arbiter #(
  parameter logic [23:0] HOLD_CYCLES  = 24'd33000,
  parameter logic [23:0] IDLE_TIMEOUT = 24'd3300000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [31:0] bcd_data,
  output logic [1:0]  owner,
  output logic        update
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic        rr;
  logic [23:0] holdCnt;
  logic        holdDone;
  logic        xfer0;
  logic        xfer1;
  logic        grant0;
  logic        grant1;
  logic        timeoutHit;

  assign owner    = state;
  assign holdDone = (holdCnt == 24'd0);
  assign xfer0    = req0_valid && req0_ready;
  assign xfer1    = req1_valid && req1_ready;
  // A grant is a transfer from a requester that does not already own the display.
  assign grant0   = xfer0 && (state != OWN0);
  assign grant1   = xfer1 && (state != OWN1);

`ifdef DISPLAY_ARB_TIMEOUT_EN
  logic [23:0] idleCnt;
  logic        owning;

  assign owning     = (state == OWN0) || (state == OWN1);
  assign timeoutHit = owning && (idleCnt == 24'd0) && holdDone && !req0_valid && !req1_valid;

  // Inactivity counter: reloads on every transfer, counts down while someone owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      idleCnt <= 24'd0;
    end else if (xfer0 || xfer1) begin
      idleCnt <= IDLE_TIMEOUT - 24'd1;
    end else if (owning && (idleCnt != 24'd0)) begin
      idleCnt <= idleCnt - 24'd1;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Ready generation and next-state selection.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    stateNext  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || !rr)) begin
          req0_ready = 1'b1;
          stateNext  = OWN0;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
          stateNext  = OWN1;
        end
      end
      OWN0: begin
        if (holdDone && req1_valid) begin
          req1_ready = 1'b1;
          stateNext  = OWN1;
        end else begin
          req0_ready = 1'b1;
        end
      end
      OWN1: begin
        if (holdDone && req0_valid) begin
          req0_ready = 1'b1;
          stateNext  = OWN0;
        end else begin
          req1_ready = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (timeoutHit) begin
      stateNext = IDLE;
    end
    // Nothing may be accepted while reset is asserted; that transfer would be lost anyway.
    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // State, round-robin, hold counter and display register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      rr       <= 1'b0;
      holdCnt  <= 24'd0;
      bcd_data <= 32'h0;
      update   <= 1'b0;
    end else begin
      state  <= stateNext;
      update <= xfer0 || xfer1;
      if (xfer0) begin
        bcd_data <= req0_data;
      end else if (xfer1) begin
        bcd_data <= req1_data;
      end
      if (grant0 || grant1) begin
        holdCnt <= HOLD_CYCLES - 24'd1;
        rr      <= grant0;
      end else if (!holdDone) begin
        holdCnt <= holdCnt - 24'd1;
      end
      if (timeoutHit) begin
        bcd_data <= 32'h0;
        update   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 24'd33000, the minimum ownership time in clk cycles (1 ms at 33 MHz).
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 24'd3300000, the inactivity time in cycles before ownership is released (used only under REQ-024).
REQ-003 SHALL have port clk, input, 1 bit: the single clock (33 MHz).
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports req0_valid (input, 1), req0_data (input, 32) and req0_ready (output, 1): requester 0 display-value handshake.
REQ-006 SHALL have ports req1_valid (input, 1), req1_data (input, 32) and req1_ready (output, 1): requester 1 display-value handshake.
REQ-007 SHALL have port bcd_data, output, 32 bits: registered eight-nibble value driven to the seven-segment scan controller.
REQ-008 SHALL have port owner, output, 2 bits: current owner, 2'b00 none, 2'b01 req0, 2'b10 req1.
REQ-009 SHALL have port update, output, 1 bit: one-cycle pulse, high in the cycle bcd_data takes a new value.

Function
REQ-010 SHALL implement an FSM with states IDLE, OWN0 and OWN1, with owner encoded directly from the state.
REQ-011 SHALL define a transfer as valid&&ready in a cycle; bcd_data SHALL equal the transferred data one cycle later, with update high in that same cycle.
REQ-012 SHALL keep one round-robin bit rr, where rr=0 favours req0 and rr=1 favours req1; every ownership grant SHALL set rr to the non-granted requester.
REQ-013 SHALL, in IDLE, grant the single valid requester, or the rr-favoured requester if both are valid, by asserting its ready combinationally in that cycle; the grant SHALL move to OWNx, load hold_cnt with HOLD_CYCLES-1 and perform the transfer.
REQ-014 SHALL hold the owner's ready high in OWNx, so every owner transfer is accepted and updates bcd_data without reloading hold_cnt.
REQ-015 SHALL hold the non-owner's ready low in OWNx while hold_cnt != 0, with hold_cnt decrementing by 1 per cycle and saturating at 0.
REQ-016 SHALL, when hold_cnt == 0 in OWNx and the non-owner is valid, assert the non-owner's ready, transfer its data, move to OWNy and reload hold_cnt.
REQ-017 SHALL, in the REQ-016 cycle, give the non-owner priority if both are valid: the owner's ready is 0 in that cycle and the owner's data is not taken.
REQ-018 SHALL, when hold_cnt == 0 and only the owner is valid, keep the current ownership and accept the owner's data.
REQ-019 SHALL hold bcd_data at its last value while no transfer occurs, with no blanking between owners.
REQ-020 SHALL keep both ready outputs free of any combinational dependence on the valid inputs except through the IDLE grant of REQ-013 and the REQ-016/017 switch selection.
REQ-021 SHALL never accept two transfers in one cycle, and at most one ready SHALL be high in any cycle.

Reset
REQ-022 SHALL, when rst is sampled high on a clk edge, set state=IDLE, bcd_data=32'h0, update=0, rr=0, hold_cnt=0 and idle_cnt=0, so that owner=2'b00 and both readys are 0 during reset.
REQ-023 SHALL, on rst asserted mid-ownership, abort that ownership on the next edge, and any transfer presented in that cycle SHALL be discarded.

Configuration
REQ-024 SHALL, with macro DISPLAY_ARB_TIMEOUT_EN defined, keep idle_cnt, which reloads to IDLE_TIMEOUT-1 on every transfer and decrements in OWNx; when it reaches 0 with hold_cnt == 0 and no valid input, the FSM SHALL return to IDLE, load bcd_data=32'h0 and pulse update.
REQ-025 SHALL, with DISPLAY_ARB_TIMEOUT_EN undefined, omit idle_cnt entirely and never leave OWNx except by a REQ-016 switch or reset.

Verification
REQ-026 SHALL cover this scenario: after reset, req0_valid with data 32'h1234_5678 -> req0_ready high in the same cycle, then bcd_data=32'h12345678, owner=01 and update=1 on the next cycle.
REQ-027 SHALL cover this scenario: both valid in IDLE after reset -> req0 granted and rr=1; a later return to IDLE with both valid -> req1 granted.
REQ-028 SHALL cover this scenario: with HOLD_CYCLES=8, req0 owns and req1 is held valid -> req1_ready stays 0 for exactly 7 cycles after the grant, then rises for one cycle while req0_ready is 0, and owner becomes 10.
REQ-029 SHALL cover this scenario: the owner sends 3 back-to-back transfers during hold -> bcd_data follows each value 1 cycle later, and the switch time is unchanged.
REQ-030 SHALL cover this scenario: rst pulsed high for 1 cycle while in OWN1 with req1_valid high -> the next cycle shows owner=00 and bcd_data=0, with no update pulse.
REQ-031 SHALL cover this scenario: with DISPLAY_ARB_TIMEOUT_EN, IDLE_TIMEOUT=16 and HOLD_CYCLES=4, one transfer then silence -> IDLE and bcd_data=0 seen 16 cycles after the transfer edge; without the macro, ownership persists for at least 1000 cycles.
